s3_maxpool_collector: RTL and testbench
=======================================

// Module: s3_maxpool_collector
// PURPOSE
// - Stage 3 of the CNN datapath, directly downstream of the stage-2 convolution core.
// - Sequences stage 2 through all 4 filters x 36 output positions, and captures each ReLU result into a 4x6x6 feature buffer.
// - Then 2x2/stride-2 max-pools the buffer into 4x3x3 and streams the 36 pooled values out over a valid/ready handshake.
// PARAMETERS
// - NFILT    4   number of conv filters (feature maps)
// - FDIM     6   conv output side length (FDIM x FDIM per filter); must be even
// - DW       36  signed data width of conv results and pooled outputs
// - PDIM     3   pooled side length, = FDIM/2 (derived, not overridable)
// PORTS
// - clk           in   1          clock, rising edge
// - rst_n         in   1          asynchronous active-low reset
// - start         in   1          1-cycle request to begin a full layer pass; sampled in IDLE only
// - proc_dir      out  2          filter select to stage 2
// - proc_counter  out  6          linear output position 0..35 to stage 2
// - conv_res      in   DW x 144   stage-2 result vector; the valid entry is at proc_dir*36+proc_counter
// - busy          out  1          high in CAPTURE and POOL
// - pool_valid    out  1          pooled sample available
// - pool_ready    in   1          downstream accepts sample
// - pool_data     out  DW signed  pooled value
// - pool_addr     out  6          f*9 + pr*3 + pc, 0..35
// - done          out  1          1-cycle pulse after the last pooled sample is accepted
// BEHAVIOUR
// - Reset (async assert, sync-deasserted use): state=IDLE; proc_dir=0, proc_counter=0, pool_addr=0; busy=0, pool_valid=0, done=0.
//   The buffer is cleared to 0, so pool_data=0.
// - FSM: IDLE -> CAPTURE -> POOL -> DONE -> IDLE.
// - IDLE: outputs are held at their reset values. A start pulse clears the counters and moves to CAPTURE on the next edge.
// - CAPTURE: stage 2 is combinational, so each cycle writes buf[proc_dir][proc_counter] <= conv_res[proc_dir*36+proc_counter].
//   - proc_counter increments from 0 to 35; on wrap it returns to 0 and proc_dir increments.
//   - After the write of (3,35), exactly 144 cycles after entry, the FSM moves to POOL with proc_dir=0 and proc_counter=0.
// - POOL: pool_valid=1 for the whole state.
//   - pool_data = signed max of buf[f][(2pr+a)*6 + 2pc+b] for a,b in {0,1}. It is combinational from pool_addr and the buffer.
//   - pool_addr advances only on pool_valid&&pool_ready. pool_data and pool_addr are held stable while ready is low.
//   - When address 35 is accepted, the FSM moves to DONE.
// - DONE: done=1 and pool_valid=0 for 1 cycle, then IDLE. pool_addr returns to 0.
// - Latency: start-to-first pool_valid = 145 cycles. Minimum start-to-done = 145+36 cycles.
// - start while not in IDLE is ignored, including in DONE.
// - Reset mid-operation aborts immediately to the reset state. Buffer contents are cleared.
// - Ties in the max select any equal value; the result is identical.
// - Values are compared as signed, so negative inputs pool correctly.
// - No truncation: the output width is DW.
// - conv_res entries other than the selected one are don't-care.
// CONFIGURATION
// - S3_POOL_AVG_EN defined: average pooling replaces max pooling.
//   - The 4 values are summed in DW+2 bits, then arithmetically shifted right by 2 (floor toward -inf).
//   - The result is truncated to DW bits; it always fits.
//   - Timing and handshake are unchanged.
// - S3_POOL_AVG_EN undefined: max pooling as above.
// TESTING
// - Reset: rst_n=0 mid-CAPTURE at cycle 50 -> busy=0, proc_dir=0, proc_counter=0, pool_valid=0 immediately.
//   Then start -> 145 cycles to pool_valid.
// - Ramp: stage-2 model returns f*100+idx, pool_ready=1 -> pool_addr 0..35 in consecutive cycles.
//   - addr0 = 7 (max of 0,1,6,7); addr4 = 21; addr9 = 107; addr35 = 335.
//   - done pulses 1 cycle after addr35.
// - Backpressure: pool_ready toggles 0,0,1 repeatedly -> each value is held 3 cycles with stable pool_addr; no value is dropped or duplicated.
// - Sequencing: record (proc_dir,proc_counter) during CAPTURE -> exactly (0,0)..(0,35),(1,0)..(3,35), each once, 144 cycles.
// - Signed/ties: window {-5,-3,-3,-9} -> max mode -3; AVG mode floor(-20/4) = -5.
//   Window {-1,0,0,0} in AVG mode -> -1.
// - start pulses during CAPTURE, POOL and DONE -> no effect.
//   A second start 1 cycle after done -> a new pass begins normally.

Source files
------------

// File: rtl/s3_maxpool_collector.sv
// Stage-3 collector: walks stage 2 over every filter/position, buffers the results, then
// streams 2x2/stride-2 pooled values. Define S3_POOL_AVG_EN for average instead of max pooling.
module s3_maxpool_collector #(
    parameter int NFILT = 4,
    parameter int FDIM  = 6,
    parameter int DW    = 36
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [1:0]                    proc_dir,
    output logic [5:0]                    proc_counter,
    input  logic [NFILT*FDIM*FDIM*DW-1:0] conv_res,
    output logic                          busy,
    output logic                          pool_valid,
    input  logic                          pool_ready,
    output logic signed [DW-1:0]          pool_data,
    output logic [5:0]                    pool_addr,
    output logic                          done
);

    localparam int PDIM  = FDIM / 2;
    localparam int NPOS  = FDIM * FDIM;
    localparam int NBUF  = NFILT * NPOS;
    localparam int NPOOL = NFILT * PDIM * PDIM;
    localparam int AW    = $clog2(NBUF);
    localparam int CW    = $clog2(NBUF * DW);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_POOL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  proc_dir_q, proc_dir_d;
    logic [5:0]  proc_counter_q, proc_counter_d;
    logic [5:0]  pool_addr_q, pool_addr_d;
    logic        busy_q, busy_d;
    logic        pool_valid_q, pool_valid_d;
    logic        done_q, done_d;

    logic signed [DW-1:0] buf_q [NBUF];

    always_comb begin
        // NOTE: every _d takes its held value first, so no branch can leave a latch behind.
        state_d        = state_q;
        proc_dir_d     = proc_dir_q;
        proc_counter_d = proc_counter_q;
        pool_addr_d    = pool_addr_q;
        busy_d         = busy_q;
        pool_valid_d   = pool_valid_q;
        done_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d        = S_CAPTURE;
                    proc_dir_d     = '0;
                    proc_counter_d = '0;
                    pool_addr_d    = '0;
                    busy_d         = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (proc_counter_q == 6'(NPOS - 1)) begin
                    proc_counter_d = '0;
                    if (proc_dir_q == 2'(NFILT - 1)) begin
                        proc_dir_d   = '0;
                        state_d      = S_POOL;
                        pool_valid_d = 1'b1;
                        pool_addr_d  = '0;
                    end else begin
                        proc_dir_d = proc_dir_q + 2'd1;
                    end
                end else begin
                    proc_counter_d = proc_counter_q + 6'd1;
                end
            end
            S_POOL: begin
                if (pool_valid_q && pool_ready) begin
                    if (pool_addr_q == 6'(NPOOL - 1)) begin
                        state_d      = S_DONE;
                        pool_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        pool_addr_d  = '0;
                    end else begin
                        pool_addr_d = pool_addr_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                pool_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            proc_dir_q     <= '0;
            proc_counter_q <= '0;
            pool_addr_q    <= '0;
            busy_q         <= 1'b0;
            pool_valid_q   <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            proc_dir_q     <= proc_dir_d;
            proc_counter_q <= proc_counter_d;
            pool_addr_q    <= pool_addr_d;
            busy_q         <= busy_d;
            pool_valid_q   <= pool_valid_d;
            done_q         <= done_d;
        end
    end

    // Stage 2 is combinational, so the selected result is valid in the same cycle it is addressed.
    logic [AW-1:0] cap_idx;
    logic [CW-1:0] cap_bit;
    assign cap_idx = AW'(proc_dir_q) * AW'(NPOS) + AW'(proc_counter_q);
    assign cap_bit = CW'(cap_idx) * CW'(DW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is part of the reset state (pool_data must read 0 after reset),
            // so every word is a resettable flop rather than an unreset RAM.
            for (int i = 0; i < NBUF; i++) buf_q[i] <= '0;
        end else if (state_q == S_CAPTURE) begin
            buf_q[cap_idx] <= conv_res[cap_bit +: DW];
        end
    end

    logic [AW-1:0]        pa, pf, prem, pr, pc, win_base;
    logic signed [DW-1:0] w [4];
    logic signed [DW-1:0] pooled;
`ifdef S3_POOL_AVG_EN
    logic signed [DW+1:0] win_sum;
    logic signed [DW+1:0] win_avg;
`else
    logic signed [DW-1:0] max_lo, max_hi;
`endif

    always_comb begin
        pa       = AW'(pool_addr_q);
        pf       = pa / AW'(PDIM * PDIM);
        prem     = pa % AW'(PDIM * PDIM);
        pr       = prem / AW'(PDIM);
        pc       = prem % AW'(PDIM);
        win_base = pf * AW'(NPOS) + pr * AW'(2 * FDIM) + pc * AW'(2);
        w[0]     = buf_q[win_base];
        w[1]     = buf_q[win_base + AW'(1)];
        w[2]     = buf_q[win_base + AW'(FDIM)];
        w[3]     = buf_q[win_base + AW'(FDIM + 1)];
`ifdef S3_POOL_AVG_EN
        // Two guard bits hold the 4-way sum; >>> floors toward -inf and the quotient fits in DW.
        win_sum = {{2{w[0][DW-1]}}, w[0]} + {{2{w[1][DW-1]}}, w[1]}
                + {{2{w[2][DW-1]}}, w[2]} + {{2{w[3][DW-1]}}, w[3]};
        win_avg = win_sum >>> 2;
        pooled  = win_avg[DW-1:0];
`else
        max_lo = (w[0] > w[1]) ? w[0] : w[1];
        max_hi = (w[2] > w[3]) ? w[2] : w[3];
        pooled = (max_lo > max_hi) ? max_lo : max_hi;
`endif
    end

    assign proc_dir     = proc_dir_q;
    assign proc_counter = proc_counter_q;
    assign pool_addr    = pool_addr_q;
    assign busy         = busy_q;
    assign pool_valid   = pool_valid_q;
    assign done         = done_q;
    assign pool_data    = pooled;

endmodule

// File: tb/tb_s3_maxpool_collector.sv
// Directed bench for s3_maxpool_collector: ramp, backpressure, signed windows, reset abort.
module tb_s3_maxpool_collector;

    localparam int NFILT = 4;
    localparam int FDIM  = 6;
    localparam int DW    = 36;
    localparam int NBUF  = NFILT * FDIM * FDIM;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [1:0]           proc_dir;
    logic [5:0]           proc_counter;
    logic [NBUF*DW-1:0]   conv_res;
    logic                 busy;
    logic                 pool_valid;
    logic                 pool_ready;
    logic signed [DW-1:0] pool_data;
    logic [5:0]           pool_addr;
    logic                 done;

    logic signed [DW-1:0] model [NBUF];

    s3_maxpool_collector #(.NFILT(NFILT), .FDIM(FDIM), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .proc_dir     (proc_dir),
        .proc_counter (proc_counter),
        .conv_res     (conv_res),
        .busy         (busy),
        .pool_valid   (pool_valid),
        .pool_ready   (pool_ready),
        .pool_data    (pool_data),
        .pool_addr    (pool_addr),
        .done         (done)
    );

    for (genvar g = 0; g < NBUF; g++) begin : g_conv
        assign conv_res[g*DW +: DW] = model[g];
    end

    always #5 clk = ~clk;

    typedef struct {
        int     addr;
        longint exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int f = 0; f < NFILT; f++)
            for (int i = 0; i < FDIM * FDIM; i++)
                model[f*36 + i] = 36'(f * 100 + i);
    endtask

    // Ramp window top-left is f*100 + 12*pr + 2*pc; max adds 7, floor-average adds 3.
    function automatic longint exp_ramp(input int a);
        int f, r, pr, pc;
        f  = a / 9;
        r  = a % 9;
        pr = r / 3;
        pc = r % 3;
`ifdef S3_POOL_AVG_EN
        return longint'(f * 100 + 12 * pr + 2 * pc + 3);
`else
        return longint'(f * 100 + 12 * pr + 2 * pc + 7);
`endif
    endfunction

    vec_t                 ramp_tab [6];
    vec_t                 sgn_tab  [4];
    logic signed [DW-1:0] got  [36];
    logic signed [DW-1:0] got2 [36];
    logic signed [DW-1:0] prev_data;
    logic [5:0]           prev_addr;
    int cyc, ncap, seq_err, addr_err, form_err, phase, n_acc, hold_err, order_err;
    bit held;

    initial begin
`ifdef S3_POOL_AVG_EN
        ramp_tab = '{'{0, 3}, '{4, 17}, '{9, 103}, '{17, 131}, '{22, 217}, '{35, 331}};
        sgn_tab  = '{'{0, -5}, '{1, -1}, '{35, -64'sd8589934598}, '{2, 7}};
`else
        ramp_tab = '{'{0, 7}, '{4, 21}, '{9, 107}, '{17, 135}, '{22, 221}, '{35, 335}};
        sgn_tab  = '{'{0, -3}, '{1, 0}, '{35, -7}, '{2, 11}};
`endif
        rst_n      = 1'b0;
        start      = 1'b0;
        pool_ready = 1'b1;
        fill_ramp();
        repeat (3) tick();

        check("reset_busy", busy, 0);
        check("reset_proc_dir", proc_dir, 0);
        check("reset_proc_counter", proc_counter, 0);
        check("reset_pool_valid", pool_valid, 0);
        check("reset_pool_addr", pool_addr, 0);
        check("reset_done", done, 0);
        check("reset_pool_data", pool_data, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Pass 1: ramp, ready held high, stray start pulses in CAPTURE/POOL/DONE.
        start = 1'b1;
        tick();
        start   = 1'b0;
        cyc     = 1;
        ncap    = 0;
        seq_err = 0;
        while (!pool_valid && cyc < 400) begin
            if (busy) begin
                if (proc_dir != 2'(ncap / 36) || proc_counter != 6'(ncap % 36)) seq_err++;
                ncap++;
            end
            start = (cyc == 60);
            tick();
            cyc++;
        end
        start = 1'b0;
        check("ramp_latency", cyc, 145);
        check("capture_count", ncap, 144);
        check("capture_sequence_errors", seq_err, 0);
        check("pool_busy", busy, 1);
        check("pool_proc_dir", proc_dir, 0);
        check("pool_proc_counter", proc_counter, 0);

        addr_err = 0;
        for (int a = 0; a < 36; a++) begin
            if (!pool_valid || pool_addr != 6'(a)) addr_err++;
            got[a] = pool_data;
            start  = (a == 10);
            tick();
        end
        start = 1'b0;
        check("ramp_addr_sequence_errors", addr_err, 0);
        check("done_pulse", done, 1);
        check("done_pool_valid", pool_valid, 0);
        check("done_pool_addr", pool_addr, 0);
        check("done_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_is_one_cycle", done, 0);
        check("start_in_done_ignored", busy, 0);

        for (int i = 0; i < 6; i++)
            check($sformatf("ramp_data_addr%0d", ramp_tab[i].addr),
                  got[ramp_tab[i].addr], ramp_tab[i].exp);
        form_err = 0;
        for (int a = 0; a < 36; a++)
            if (longint'(got[a]) != exp_ramp(a)) form_err++;
        check("ramp_all_addr_errors", form_err, 0);

        // Pass 2 starts one cycle after done: signed windows under 0,0,1 backpressure.
        fill_ramp();
        model[0]   = -36'sd5;
        model[1]   = -36'sd3;
        model[6]   = -36'sd3;
        model[7]   = -36'sd9;
        model[2]   = -36'sd1;
        model[3]   = 36'sd0;
        model[8]   = 36'sd0;
        model[9]   = 36'sd0;
        model[136] = -36'sd7;
        model[137] = -36'sd8;
        model[142] = -36'sd9;
        model[143] = {1'b1, 35'b0};
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy", busy, 1);
        cyc = 1;
        while (!pool_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        check("restart_latency", cyc, 145);

        phase     = 0;
        n_acc     = 0;
        hold_err  = 0;
        order_err = 0;
        held      = 1'b0;
        cyc       = 0;
        prev_addr = '0;
        prev_data = '0;
        while (!done && cyc < 400) begin
            pool_ready = (phase == 2);
            if (pool_valid) begin
                if (held && (pool_addr != prev_addr || pool_data !== prev_data)) hold_err++;
                if (pool_ready) begin
                    if (pool_addr != 6'(n_acc)) order_err++;
                    if (pool_addr < 6'd36) got2[pool_addr] = pool_data;
                    n_acc++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                end
                prev_addr = pool_addr;
                prev_data = pool_data;
            end
            phase = (phase == 2) ? 0 : phase + 1;
            tick();
            cyc++;
        end
        pool_ready = 1'b1;
        check("bp_pool_cycles", cyc, 108);
        check("bp_accepted", n_acc, 36);
        check("bp_hold_errors", hold_err, 0);
        check("bp_order_errors", order_err, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("signed_data_addr%0d", sgn_tab[i].addr),
                  got2[sgn_tab[i].addr], sgn_tab[i].exp);
        form_err = 0;
        for (int a = 2; a < 35; a++)
            if (longint'(got2[a]) != exp_ramp(a)) form_err++;
        check("bp_ramp_addr_errors", form_err, 0);
        tick();

        // Pass 3: reset asserted asynchronously in cycle 50 of CAPTURE.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        check("pre_abort_proc_dir", proc_dir, 1);
        check("pre_abort_proc_counter", proc_counter, 13);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_proc_dir", proc_dir, 0);
        check("abort_proc_counter", proc_counter, 0);
        check("abort_pool_valid", pool_valid, 0);
        check("abort_buffer_cleared", pool_data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!pool_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        check("post_abort_latency", cyc, 145);
        check("post_abort_addr0", pool_data, sgn_tab[0].exp);
        cyc = 0;
        while (!done && cyc < 100) begin
            tick();
            cyc++;
        end
        check("post_abort_drain_cycles", cyc, 36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
